// File: rtl/i2c_slave_pkg.sv
// Shared encodings for the I2C target byte engine and any future I2C monitor.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_DATA  = 4'd3,
    ST_WR_ACK   = 4'd4,
    ST_RD_DATA  = 4'd5,
    ST_RD_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_slave_sync_edge.sv
// Synchronises SCL/SDA into CLK and flags SCL edges plus START/STOP conditions.
// Events are combinational from the last synchronised sample and its history flop.
module i2c_slave_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic SCL_I,
  input  logic SDA_I,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_cur;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_I};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_I};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_cur  = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = !scl_prev && scl_cur;
  assign scl_fall = scl_prev && !scl_cur;
  // SDA may only move while SCL is high for a START/STOP; require SCL high on both samples.
  assign start    = scl_prev && scl_cur && sda_prev && !sda;
  assign stop     = scl_prev && scl_cur && !sda_prev && sda;

endmodule

// File: rtl/i2c_slave_byte.sv
// I2C target byte engine: address match, ACK/NACK, write-byte capture and read-byte shift-out.
// SDA only changes after a synchronised SCL fall; data is sampled on the synchronised SCL rise.
module i2c_slave_byte
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_O,
  output logic       SDA_T,
  input  logic       ACK_EN,
  output logic       RX_VALID,
  output logic [7:0] rx_data,
  output logic       TX_REQ,
  input  logic [7:0] tx_data,
  output logic       START_DET,
  output logic       STOP_DET,
  output logic       ADDR_HIT,
  output logic       RW,
  output logic       NACKED,
  output logic       BUSY
);

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] shreg;
  logic [6:0] txsh;
  logic       ack_drv;
  logic       ack_en_q;

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_slave_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .SCL_I    (SCL_I),
    .SDA_I    (SDA_I),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      shreg     <= 7'd0;
      txsh      <= 7'd0;
      ack_drv   <= 1'b0;
      ack_en_q  <= 1'b0;
      SDA_O     <= 1'b1;
      rx_data   <= 8'd0;
      RW        <= 1'b0;
      NACKED    <= 1'b0;
      RX_VALID  <= 1'b0;
      TX_REQ    <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
      ADDR_HIT  <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      TX_REQ    <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
      ADDR_HIT  <= 1'b0;
      if (stop) begin
        STOP_DET <= 1'b1;
        SDA_O    <= 1'b1;
        ack_drv  <= 1'b0;
        state    <= ST_IDLE;
      end else if (start) begin
        START_DET <= 1'b1;
        NACKED    <= 1'b0;
        cnt       <= 4'd0;
        SDA_O     <= 1'b1;
        ack_drv   <= 1'b0;
        state     <= ST_ADDR;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: if (scl_rise) begin
            shreg <= {shreg[5:0], sda};
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              if (shreg == SLAVE_ADDR) begin
                RW       <= sda;
                ADDR_HIT <= 1'b1;
                TX_REQ   <= sda;
                ack_drv  <= 1'b0;
                state    <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              SDA_O   <= I2C_ACK;
              ack_drv <= 1'b1;
            end else begin
              ack_drv <= 1'b0;
              if (RW) begin
                SDA_O <= tx_data[7];
                txsh  <= tx_data[6:0];
                cnt   <= 4'd1;
                state <= ST_RD_DATA;
              end else begin
                SDA_O <= 1'b1;
                cnt   <= 4'd0;
                state <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shreg <= {shreg[5:0], sda};
            if (cnt == 4'd7) begin
              rx_data  <= {shreg, sda};
              RX_VALID <= 1'b1;
              cnt      <= 4'd0;
              ack_drv  <= 1'b0;
              state    <= ST_WR_ACK;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ST_WR_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              SDA_O    <= ACK_EN ? I2C_ACK : I2C_NACK;
              ack_en_q <= ACK_EN;
              ack_drv  <= 1'b1;
            end else begin
              SDA_O   <= 1'b1;
              ack_drv <= 1'b0;
              cnt     <= 4'd0;
              state   <= ack_en_q ? ST_WR_DATA : ST_IGNORE;
            end
          end
          // cnt==0 means a fresh byte must be loaded; cnt==8 means bit 0 has been held.
          ST_RD_DATA: if (scl_fall) begin
            if (cnt == 4'd0) begin
              SDA_O <= tx_data[7];
              txsh  <= tx_data[6:0];
              cnt   <= 4'd1;
            end else if (cnt == 4'd8) begin
              SDA_O <= 1'b1;
              cnt   <= 4'd0;
              state <= ST_RD_ACK;
            end else begin
              SDA_O <= txsh[6];
              txsh  <= {txsh[5:0], 1'b0};
              cnt   <= cnt + 4'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (sda == I2C_ACK) begin
              TX_REQ <= 1'b1;
              cnt    <= 4'd0;
              state  <= ST_RD_DATA;
            end else begin
              NACKED <= 1'b1;
              state  <= ST_IGNORE;
            end
          end
          ST_IGNORE: SDA_O <= 1'b1;
          default: begin
            SDA_O <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign SDA_T = SDA_O;
  assign BUSY  = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_byte.sv
// Directed bench: a behavioural I2C master drives the bus, and each scenario checks its own results.
module tb_i2c_slave_byte;
  import i2c_slave_pkg::*;

  localparam time Q = 40ns;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       ACK_EN = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       SDA_O, SDA_T, RX_VALID, TX_REQ, START_DET, STOP_DET, ADDR_HIT, RW, NACKED, BUSY;
  logic [7:0] rx_data;
  logic       sda_bus;

  int total = 0;
  int bad = 0;
  int n_start = 0, n_stop = 0, n_hit = 0, n_rx = 0, n_txreq = 0;
  logic [7:0] rx_log[$];

  assign sda_bus = sda_m & (SDA_T ? 1'b1 : SDA_O);

  i2c_slave_byte dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SCL_I     (scl_m),
    .SDA_I     (sda_bus),
    .SDA_O     (SDA_O),
    .SDA_T     (SDA_T),
    .ACK_EN    (ACK_EN),
    .RX_VALID  (RX_VALID),
    .rx_data   (rx_data),
    .TX_REQ    (TX_REQ),
    .tx_data   (tx_data),
    .START_DET (START_DET),
    .STOP_DET  (STOP_DET),
    .ADDR_HIT  (ADDR_HIT),
    .RW        (RW),
    .NACKED    (NACKED),
    .BUSY      (BUSY)
  );

  always #5ns CLK = ~CLK;

  always @(negedge CLK) begin
    if (START_DET) n_start++;
    if (STOP_DET)  n_stop++;
    if (ADDR_HIT)  n_hit++;
    if (TX_REQ)    n_txreq++;
    if (RX_VALID) begin
      n_rx++;
      rx_log.push_back(rx_data);
    end
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic v, output logic s);
    sda_m = v; #Q;
    scl_m = 1'b1; #Q;
    s = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i], b);
    write_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      write_bit(1'b1, b);
      d[i] = b;
    end
    tx_data = next_tx;
    write_bit(m_ack ? 1'b0 : 1'b1, b);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (SDA_O !== 1'b1) begin bad++; $display("FAIL reset_sda_o got=%b exp=1", SDA_O); end
    total++; if (SDA_T !== 1'b1) begin bad++; $display("FAIL reset_sda_t got=%b exp=1", SDA_T); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if ({BUSY, RW, NACKED} !== 3'b000) begin bad++; $display("FAIL reset_levels got=%b exp=000", {BUSY, RW, NACKED}); end
    total++; if ({RX_VALID, TX_REQ, START_DET, STOP_DET, ADDR_HIT} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=00000", {RX_VALID, TX_REQ, START_DET, STOP_DET, ADDR_HIT});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_write();
    int s0, p0, h0, r0;
    logic a0, a1, a2;
    s0 = n_start; p0 = n_stop; h0 = n_hit; r0 = n_rx;
    rx_log.delete();
    ACK_EN = 1'b1;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", BUSY); end
    i2c_stop();
    repeat (6) @(negedge CLK);
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wr_acks got=%b exp=000", {a0, a1, a2}); end
    total++; if (n_start - s0 != 1) begin bad++; $display("FAIL wr_start_det got=%0d exp=1", n_start - s0); end
    total++; if (n_hit - h0 != 1) begin bad++; $display("FAIL wr_addr_hit got=%0d exp=1", n_hit - h0); end
    total++; if (n_rx - r0 != 2) begin bad++; $display("FAIL wr_rx_valid got=%0d exp=2", n_rx - r0); end
    total++; if ((rx_log.size() > 0 ? rx_log[0] : 8'hxx) !== 8'hA5) begin
      bad++; $display("FAIL wr_byte0 got=%h exp=a5", rx_log.size() > 0 ? rx_log[0] : 8'hxx);
    end
    total++; if ((rx_log.size() > 1 ? rx_log[1] : 8'hxx) !== 8'h3C) begin
      bad++; $display("FAIL wr_byte1 got=%h exp=3c", rx_log.size() > 1 ? rx_log[1] : 8'hxx);
    end
    total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL wr_stop_det got=%0d exp=1", n_stop - p0); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL wr_idle_after got=%b exp=0", BUSY); end
    total++; if (RW !== 1'b0) begin bad++; $display("FAIL wr_rw got=%b exp=0", RW); end
  endtask

  task automatic test_wrong_addr();
    int h0, r0;
    logic a0, a1;
    h0 = n_hit; r0 = n_rx;
    i2c_start();
    write_byte(8'hA2, a0);
    total++; if (dut.state !== ST_IGNORE) begin bad++; $display("FAIL bad_addr_state got=%0d exp=%0d", dut.state, ST_IGNORE); end
    write_byte(8'h11, a1);
    total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL bad_addr_nack got=%b exp=11", {a0, a1}); end
    total++; if (dut.state !== ST_IGNORE) begin bad++; $display("FAIL bad_addr_hold got=%0d exp=%0d", dut.state, ST_IGNORE); end
    total++; if ((n_hit - h0) + (n_rx - r0) != 0) begin
      bad++; $display("FAIL bad_addr_pulses got=%0d exp=0", (n_hit - h0) + (n_rx - r0));
    end
    i2c_stop();
    repeat (6) @(negedge CLK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL bad_addr_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_read();
    int t0;
    logic a0;
    logic [7:0] d0, d1;
    t0 = n_txreq;
    tx_data = 8'hC3;
    i2c_start();
    write_byte(8'hA1, a0);
    read_byte(1'b1, 8'h81, d0);
    read_byte(1'b0, 8'h00, d1);
    repeat (4) @(negedge CLK);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", a0); end
    total++; if (d0 !== 8'hC3) begin bad++; $display("FAIL rd_byte0 got=%h exp=c3", d0); end
    total++; if (d1 !== 8'h81) begin bad++; $display("FAIL rd_byte1 got=%h exp=81", d1); end
    total++; if (n_txreq - t0 != 2) begin bad++; $display("FAIL rd_tx_req got=%0d exp=2", n_txreq - t0); end
    total++; if (NACKED !== 1'b1) begin bad++; $display("FAIL rd_nacked got=%b exp=1", NACKED); end
    total++; if (SDA_O !== 1'b1) begin bad++; $display("FAIL rd_released got=%b exp=1", SDA_O); end
    total++; if (RW !== 1'b1) begin bad++; $display("FAIL rd_rw got=%b exp=1", RW); end
    i2c_stop();
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_repeated_start();
    int s0, p0;
    logic a0, a1, a2;
    logic [7:0] d0;
    s0 = n_start; p0 = n_stop;
    tx_data = 8'h5A;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h10, a1);
    total++; if (NACKED !== 1'b0) begin bad++; $display("FAIL rs_nacked_cleared got=%b exp=0", NACKED); end
    total++; if (RW !== 1'b0) begin bad++; $display("FAIL rs_rw_write got=%b exp=0", RW); end
    total++; if (rx_data !== 8'h10) begin bad++; $display("FAIL rs_rx_data got=%h exp=10", rx_data); end
    i2c_start();
    write_byte(8'hA1, a2);
    total++; if (RW !== 1'b1) begin bad++; $display("FAIL rs_rw_read got=%b exp=1", RW); end
    total++; if (n_start - s0 != 2) begin bad++; $display("FAIL rs_start_det got=%0d exp=2", n_start - s0); end
    read_byte(1'b0, 8'h00, d0);
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rs_acks got=%b exp=000", {a0, a1, a2}); end
    total++; if (d0 !== 8'h5A) begin bad++; $display("FAIL rs_read_byte got=%h exp=5a", d0); end
    total++; if (n_stop != p0) begin bad++; $display("FAIL rs_no_stop got=%0d exp=0", n_stop - p0); end
    i2c_stop();
    repeat (6) @(negedge CLK);
    total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL rs_final_stop got=%0d exp=1", n_stop - p0); end
  endtask

  task automatic test_ack_en_off();
    int r0;
    logic a0, a1, a2;
    r0 = n_rx;
    ACK_EN = 1'b1;
    i2c_start();
    write_byte(8'hA0, a0);
    ACK_EN = 1'b0;
    write_byte(8'h77, a1);
    total++; if (n_rx - r0 != 1) begin bad++; $display("FAIL nak_rx_valid got=%0d exp=1", n_rx - r0); end
    total++; if (rx_data !== 8'h77) begin bad++; $display("FAIL nak_rx_data got=%h exp=77", rx_data); end
    ACK_EN = 1'b1;
    write_byte(8'h12, a2);
    total++; if ({a0, a1, a2} !== 3'b011) begin bad++; $display("FAIL nak_acks got=%b exp=011", {a0, a1, a2}); end
    total++; if (n_rx - r0 != 1) begin bad++; $display("FAIL nak_ignored got=%0d exp=1", n_rx - r0); end
    total++; if (dut.state !== ST_IGNORE) begin bad++; $display("FAIL nak_state got=%0d exp=%0d", dut.state, ST_IGNORE); end
    i2c_stop();
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int h0;
    logic b, a0, a1;
    logic [7:0] addr;
    h0 = n_hit;
    addr = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr[i], b);
    sda_m = 1'b1; #Q;
    total++; if (SDA_O !== 1'b0) begin bad++; $display("FAIL mid_ack_driven got=%b exp=0", SDA_O); end
    @(negedge CLK);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    total++; if (SDA_O !== 1'b1) begin bad++; $display("FAIL mid_reset_release got=%b exp=1", SDA_O); end
    @(negedge CLK);
    RESET_N = 1'b1;
    #Q;
    scl_m = 1'b1; #Q; #Q;
    scl_m = 1'b0; #Q;
    write_byte(8'hA0, a0);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_stays_idle got=%b exp=0", BUSY); end
    total++; if (n_hit - h0 != 1) begin bad++; $display("FAIL mid_no_hit got=%0d exp=1", n_hit - h0); end
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL mid_no_ack got=%b exp=1", a0); end
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h42, a1);
    i2c_stop();
    repeat (6) @(negedge CLK);
    total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL mid_fresh_acks got=%b exp=00", {a0, a1}); end
    total++; if (rx_data !== 8'h42) begin bad++; $display("FAIL mid_fresh_data got=%h exp=42", rx_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_ack_en_off();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte.md
Name: i2c_slave_byte

Overview:
- I2C target (slave) byte engine: the responder side of the I2C master byte engine on the same bus.
- Oversamples SCL/SDA on CLK, detects START, repeated START and STOP, matches a 7-bit address, and ACKs.
- Shifts write bytes in, and read bytes out, through a simple one-byte handshake toward a register-file or AXI-lite front end.
- Sits between the SCL/SDA pad buffers and the target-side register block.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to
- SYNC_STAGES, 2, synchroniser depth for SCL_I/SDA_I (min 2)

Ports:
- CLK  input  1  system clock; SCL frequency ≤ CLK/8
- RESET_N  input  1  synchronous, active-low reset
- SCL_I  input  1  bus SCL (asynchronous)
- SDA_I  input  1  bus SDA (asynchronous)
- SDA_O  output  1  SDA drive value; 0 = pull low
- SDA_T  output  1  tri-state control; 1 = release (equals SDA_O)
- ACK_EN  input  1  1 = ACK received bytes, 0 = NACK them
- RX_VALID  output  1  one-CLK pulse: rx_data holds a new written byte
- rx_data  output  8  last byte written by master
- TX_REQ  output  1  one-CLK pulse: front end must present next read byte
- tx_data  input  8  read byte, sampled at SCL fall after TX_REQ
- START_DET  output  1  one-CLK pulse on START or repeated START
- STOP_DET  output  1  one-CLK pulse on STOP
- ADDR_HIT  output  1  one-CLK pulse on address match
- RW  output  1  R/W bit of the current transfer (1 = read)
- NACKED  output  1  level: master NACKed the last read byte; cleared on START
- BUSY  output  1  state != ST_IDLE

Behaviour:
- Reset (RESET_N=0 at a CLK edge) sets SDA_O=1, rx_data=0, RW=0, NACKED=0, all pulses 0, state=ST_IDLE, cnt=0, and the sync flops to 1.
- Reset mid-transfer releases SDA immediately on the next CLK edge.
- Input synchronisation: SYNC_STAGES flops per line, plus one history flop.
- Input events:
  - scl_rise = !prev & cur on synchronised SCL.
  - scl_fall = prev & !cur on synchronised SCL.
  - start = SDA falls while SCL high.
  - stop = SDA rises while SCL high.
- Priority: stop > start > SCL edge events, evaluated in any state.
- start: pulse START_DET, clear NACKED, cnt=0, SDA_O=1, go to ST_ADDR. This covers a repeated START mid-byte.
- stop: pulse STOP_DET, SDA_O=1, go to ST_IDLE.
- Data is sampled on scl_rise. SDA_O changes only on scl_fall, never while SCL is high.
- States:
  - ST_IDLE: wait for start.
  - ST_ADDR: shift 8 bits on scl_rise (MSB first).
    - After bit 8 with shreg[7:1]==SLAVE_ADDR: latch RW=bit0, pulse ADDR_HIT, go to ST_ADDR_ACK.
    - If RW=1, also pulse TX_REQ on the same cycle.
    - Mismatch: go to ST_IGNORE.
  - ST_ADDR_ACK: on scl_fall drive SDA_O=0. On the next scl_fall:
    - RW=0: release SDA, go to ST_WR_DATA, cnt=0.
    - RW=1: load tx_data, drive bit7, go to ST_RD_DATA, cnt=1.
  - ST_WR_DATA: on the 8th scl_rise, copy shreg to rx_data, pulse RX_VALID, go to ST_WR_ACK.
  - ST_WR_ACK: on scl_fall drive SDA_O=!ACK_EN. On the next scl_fall release SDA.
    - ACK_EN was 1: go to ST_WR_DATA.
    - ACK_EN was 0: go to ST_IGNORE.
  - ST_RD_DATA: on each scl_fall drive the next bit. After bit 0 has been held through its SCL high, release SDA on scl_fall and go to ST_RD_ACK.
  - ST_RD_ACK: on scl_rise sample SDA.
    - 0 (ACK): pulse TX_REQ and go to ST_RD_DATA. tx_data is loaded on the next scl_fall and bit7 driven.
    - 1 (NACK): set NACKED, go to ST_IGNORE.
  - ST_IGNORE: SDA released; wait for start or stop.
- Handshake: tx_data must be stable from TX_REQ+2 CLK until the following scl_fall. rx_data is held until the next RX_VALID.
- Clock stretching is not supported.
- cnt is 4 bits and counts 0..8, wrapping to 0 on each byte.

Decomposition:
- i2c_slave_pkg holds:
  - state encodings ST_IDLE..ST_IGNORE (4-bit);
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - the default address constant.
- One sub-module, i2c_slave_sync_edge, contains the synchronisers and the scl_rise/scl_fall/start/stop event detector. Reuse it for any future I2C monitor.

Test Plan:
- Write 0x50 W, data 0xA5, 0x3C, STOP with ACK_EN=1:
  - START_DET and ADDR_HIT pulse; ACK seen on both the address and the data slots.
  - RX_VALID pulses twice, with rx_data=0xA5 then 0x3C.
  - STOP_DET pulses; BUSY=0 afterwards.
- Address 0x51 W: no ACK (SDA released at the 9th SCL), no ADDR_HIT or RX_VALID, state ST_IGNORE until STOP.
- Read 0x50 R, tx_data=0xC3 then 0x81, master ACK then NACK:
  - Bus carries 0xC3 then 0x81, with two TX_REQ pulses.
  - NACKED=1 after the second byte; SDA released.
- Write 0x50 W 0x10, then repeated START, then 0x50 R:
  - RW goes 0→1, with a START_DET pulse at the repeated START.
  - Read byte equals tx_data; no STOP_DET until the final STOP.
- ACK_EN=0 on a data byte: NACK is driven on the 9th clock, RX_VALID still pulses, and the following bytes are ignored.
- Assert RESET_N=0 while the target is driving ACK low: SDA_O=1 at the next CLK edge. After release, the block stays idle until a fresh START.
